// File: rtl/step_sequencer.sv
// step_sequencer: timestep sequencer for the 4-register, 10-bit-instruction
// processor. Fetches one instruction per valid/ready handshake, decodes its
// length (2, 3 or 4 steps), drives t/instr_out to the instruction controller,
// and cross-checks the controller's clr strobe against the decoded length.
//
// Build option: define SINGLE_STEP_EN to gate every FETCH/EX transition on
// the step input; undefined, step is ignored and the sequencer free-runs.
module step_sequencer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [9:0]       instr_in,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic             clr,
   input  logic             step,
   output logic [1:0]       t,
   output logic [9:0]       instr_out,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             seq_err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EX1   = 3'd2,
      EX2   = 3'd3,
      EX3   = 3'd4
   } state_t;

   state_t           state;
   logic [1:0]       t_q;
   logic [9:0]       ir_q;
   logic [1:0]       last_q;     // timestep value of the final EX state
   logic             ill_q;      // captured instruction has an illegal opcode
   logic             done_q;
   logic             illegal_q;
   logic             seq_err_q;
   logic [CNT_W-1:0] retired_q;
   logic             adv;
   logic             is_last;

   // Final timestep for an instruction: 1 (EX1), 2 (EX2) or 3 (EX3).
   function automatic logic [1:0] decode_last(input logic [9:0] instr);
      logic [1:0] last;
      last = 2'd3;
      if (instr[9]) begin
         last = 2'd3;
      end else begin
         case (instr[3:0])
            4'b0000, 4'b0001:                   last = 2'd1;
            4'b0100, 4'b0101:                   last = 2'd2;
            4'b1100, 4'b1101, 4'b1110, 4'b1111: last = 2'd1;
            default:                            last = 2'd3;
         endcase
      end
      return last;
   endfunction

   // Opcodes with FN 1100-1111 are undefined (immediate forms are always legal).
   function automatic logic decode_illegal(input logic [9:0] instr);
      return (!instr[9]) && (instr[3:2] == 2'b11);
   endfunction

`ifdef SINGLE_STEP_EN
   assign adv = step;
`else
   logic unused_step;
   assign unused_step = step;
   assign adv         = 1'b1;
`endif

   assign is_last     = (t_q == last_q);
   assign instr_ready = (state == FETCH) && adv;
   assign instr_out   = (state == FETCH) ? instr_in : ir_q;
   assign t           = t_q;
   assign busy        = (state != IDLE);
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign seq_err     = seq_err_q;
   assign retired     = retired_q;

   // Sequencer FSM with registered timestep, status pulses and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         t_q       <= '0;
         ir_q      <= '0;
         last_q    <= '0;
         ill_q     <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         seq_err_q <= 1'b0;
         retired_q <= '0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state)
            IDLE: begin
               t_q <= 2'd0;
               if (run) begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (instr_valid && adv) begin
                  ir_q   <= instr_in;
                  last_q <= decode_last(instr_in);
                  ill_q  <= decode_illegal(instr_in);
                  state  <= EX1;
                  t_q    <= 2'd1;
               end
            end
            EX1, EX2, EX3: begin
               if (adv) begin
                  if (clr != is_last) begin
                     seq_err_q <= 1'b1;
                  end
                  if (is_last) begin
                     state     <= run ? FETCH : IDLE;
                     t_q       <= 2'd0;
                     done_q    <= 1'b1;
                     illegal_q <= ill_q;
                     retired_q <= retired_q + 1'b1;
                  end else begin
                     state <= (state == EX1) ? EX2 : EX3;
                     t_q   <= t_q + 2'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               t_q   <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Timestep sequencer for the 4-register, 10-bit-instruction processor. It fetches one instruction at a time over a valid/ready handshake and drives the timestep `t` plus the instruction word `instr_out` into the combinational instruction controller. It decodes each instruction's length itself (2, 3 or 4 steps) so the controller never sees an undefined timestep. It cross-checks the controller's `clr` against that length and flags any mismatch.

## Interface
- `CNT_W`, default 8: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `run`  in  1  enables fetching; sampled in IDLE and at instruction end.
- `instr_in`  in  10  instruction from the source; valid when `instr_valid`=1.
- `instr_valid`  in  1  source has an instruction.
- `instr_ready`  out  1  sequencer accepts `instr_in` this cycle.
- `clr`  in  1  end-of-instruction strobe from the controller.
- `step`  in  1  single-step advance; used only with `SINGLE_STEP_EN`.
- `t`  out  2  timestep to the controller.
- `instr_out`  out  10  instruction to the controller.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after an instruction's last step.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for an illegal opcode.
- `seq_err`  out  1  sticky flag: `clr` disagreed with the decoded length.
- `retired`  out  CNT_W  count of completed instructions; wraps.

## Operation
- States: IDLE, FETCH (t=00), EX1 (t=01), EX2 (t=10), EX3 (t=11). In IDLE, t=00.
- `instr_out` = `instr_in` in FETCH; otherwise the captured register `ir_q`.
- **IDLE**: go to FETCH when `run`=1.
- **FETCH**: `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`: capture `ir_q` and the decoded length, then go to EX1.
  - Otherwise stay in FETCH.
- **Length decode**:
  - `instr[9]`=1 (immediate add/sub): 4 steps.
  - FN=`instr[3:0]` 0000 or 0001 (LOAD/COPY): 2 steps.
  - FN 0100 or 0101 (INV/FLP): 3 steps.
  - FN 0010, 0011, or 0110–1011: 4 steps.
  - FN 1100–1111: illegal, 2 steps.
- **Sequencing**: EX1 → EX2 → EX3. The last step is EX1, EX2 or EX3 for length 2, 3 or 4.
- **After the last step**:
  - Go to FETCH if `run`=1, else IDLE.
  - Next cycle: `done`=1, `retired`+1 (wraps at 2^CNT_W), and `illegal`=1 if the opcode was illegal.
- **Clr check**: in each EX state, if `clr` ≠ (this is the last step), set `seq_err`=1. It stays set until reset. Sequencing is unaffected.
- **Run drop**: `run` falling mid-instruction does not abort it. The instruction completes, then the sequencer enters IDLE.
- **Asynchronous reset** (any state, including mid-instruction):
  - State IDLE, `t`=00, `ir_q`=0, `retired`=0.
  - `instr_ready`, `busy`, `done`, `illegal` and `seq_err` all 0.
  - `instr_out` = `ir_q` = 0.

## Timing
- **Handshake**:
  - `instr_ready` is a Moore output: 1 only in FETCH.
  - Transfer happens on the edge where both `instr_valid` and `instr_ready` are high.
  - The source holds `instr_in` stable while `instr_valid`=1 and not yet accepted.
- **Throughput**: back-to-back instructions with `run`=1 and `instr_valid` held high take 1 fetch cycle + length−1 execute cycles:
  - 2, 3 or 4 cycles per instruction.
  - No bubble between instructions.
- **`done`/`illegal`**: registered; high exactly in the cycle after the last EX state. That cycle is FETCH or IDLE.
- `t` and `instr_out` change only on clock edges, or on reset assertion.

## Configuration
- `SINGLE_STEP_EN` defined:
  - Transitions out of FETCH and out of EX states occur only on cycles with `step`=1.
  - In FETCH, `instr_ready` = `step`.
  - IDLE→FETCH does not require `step`.
  - The clr check runs only on cycles with `step`=1.
- `SINGLE_STEP_EN` undefined: `step` is ignored and the sequencer free-runs as described above.

## Test plan
- **Reset mid-EX2**: apply reset while executing 10'h062, then release → `t`=00, `busy`=0, `retired`=0, `seq_err`=0, `instr_out`=10'h000.
- **Back-to-back stream**: `run`=1, `instr_valid`=1, stream 10'h0C0 (LOAD), 10'h014 (INV), 10'h062 (ADD), 10'h285 (ADDI).
  - `t` = 00,01 | 00,01,10 | 00,01,10,11 | 00,01,10,11.
  - Four `done` pulses; `retired`=4.
- **Stalled fetch**: `instr_valid` low for 3 cycles in FETCH → `t` held at 00 with `instr_ready`=1. When 10'h062 is then offered, it is accepted on the first edge.
- **Illegal opcode**: 10'h00C → EX1 only, then `done`=1 and `illegal`=1 for one cycle; `retired`+1.
- **Clr mismatch**: drive `clr`=1 in EX1 of 10'h062 → `seq_err`=1 and stays 1. The instruction still runs through EX3.
- **Run drop and single-step**:
  - Drop `run` in EX2 of 10'h062 → EX3 completes, then IDLE with `busy`=0.
  - With `SINGLE_STEP_EN`, `step` pulsed every 3rd cycle → `t` advances only on those cycles.
